quad_dec: RTL and testbench
===========================

# quad_dec

Parametrised multi-channel quadrature encoder decoder. Each channel synchronises and glitch-filters an A/B pair, then decodes Gray-code transitions into a signed-direction position count. Counting resolution is run-time selectable (x1/x2/x4), and illegal transitions raise a sticky error. The block sits between board-level encoder pins and the register/bus layer; the existing simulation stimulus generators (clock, reset, bouncing key, quadrature step) drive it directly in the bench.

## Interface
- CH, 2, number of independent encoder channels (≥1)
- CNT_W, 16, position counter width per channel
- FILT_LEN, 8, consecutive stable cycles required to accept a new input level (≥1)
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-low
- a_i  in  CH  raw encoder A inputs, asynchronous
- b_i  in  CH  raw encoder B inputs, asynchronous
- mode_i  in  2  resolution: 0=x1, 1=x2, 2=x4, 3=x4; shared by all channels
- clr_i  in  CH  synchronous per-channel position clear
- err_clr_i  in  CH  synchronous per-channel error clear
- pos_o  out  CH×CNT_W  position count per channel
- dir_o  out  CH  direction of last counted step: 1=forward, 0=reverse
- step_o  out  CH  one-cycle pulse per counted step
- err_o  out  CH  sticky illegal-transition flag

## Operation
- Per line: two-flop synchroniser (s1, s2) → filter. The filter counter increments while s2≠filt and clears when s2=filt. filt takes s2 on the edge where the counter equals FILT_LEN-1 with mismatch still present.
- Prime phase: during the first 3 rising edges after reset release, filt loads s2 directly. No counting, no error, no step during this phase. Counting is enabled from edge 4.
- State {A,B} is filtered. Forward sequence: 00→10→11→01→00. Reverse sequence is the opposite.
- x4: every valid transition counts ±1.
- x2: only A-changing transitions count. Forward: 00→10, 11→01. Reverse: 10→00, 01→11.
- x1: forward on 00→10 only; reverse on 10→00 only.
- Both bits change in the same cycle: err_o set; pos, dir and step unchanged.
- Non-counted valid transitions update only the stored previous state.
- Position arithmetic is modulo 2^CNT_W. Forward from all-ones gives 0; reverse from 0 gives all-ones.
- clr_i has priority over a same-cycle step: pos=0, step_o still pulses, dir_o still updates.
- err_clr_i has priority over a same-cycle new error: err_o=0.
- mode_i changes take effect on the next edge; pos is not altered.
- Channels are fully independent.
- Reset values: pos_o=0, dir_o=0, step_o=0, err_o=0. Synchroniser, filter, filter counter and previous-state registers all 0; prime counter 0.

## Timing
- Input level first captured in s1 at edge n. filt updates at edge n+FILT_LEN+1. pos_o, step_o and dir_o update at edge n+FILT_LEN+2.
- Any glitch shorter than FILT_LEN cycles, measured at s2, is fully rejected.
- Throughput: at most one step per channel per cycle. Input phases must each last ≥FILT_LEN+1 cycles to be decoded.
- Reset asserted mid-operation: all state clears immediately. On release the block re-enters the prime phase, so no spurious step occurs even if inputs rest at 11.
- All outputs are registered.

## Structure
- quad_dec_pkg holds:
  - enum mode_e: MODE_X1, MODE_X2, MODE_X4, MODE_X4B.
  - Pure function for transition decode, returning a step/direction/error struct from (prev, cur, mode).
- Sub-module quad_dec_filt: synchroniser plus glitch filter for one line, parametrised by FILT_LEN. Instantiated 2×CH times.
- quad_dec contains a generate loop per channel: prime counter, previous state, decode, counter, error flag.

## Test plan
- Reset with a_i=b_i=all-ones, release → all outputs 0; no step_o in the following 50 cycles; pos_o stays 0.
- x4, FILT_LEN=8, channel 0, 10 forward cycles with 20-clk phases → pos=40, dir=1, exactly 40 step pulses. Then 3 reverse cycles → pos=28, dir=0.
- 5 forward cycles in x1 → pos=5; same in x2 → pos=10. 5 reverse cycles return each to 0.
- A line bounces (3-cycle lows, 30 times), then goes stable high → exactly one step after FILT_LEN+2 edges of stability; pos=+1.
- CNT_W=4, x4: 16 forward steps from 0 → pos=15 then 0. One reverse step → 15. clr_i coincident with a step → pos=0, step_o=1.
- Channel 0 inputs forced 00→11 in one cycle → err_o[0]=1 sticky, pos unchanged, channel 1 unaffected. err_clr_i[0] for one cycle → err_o[0]=0.

Source files
------------

// File: rtl/quad_dec_pkg.sv
// Shared types and the Gray-code transition decoder for quad_dec.
// Pure combinational helpers; no state, no backpressure.
package quad_dec_pkg;

   typedef enum logic [1:0] {
      MODE_X1  = 2'd0,
      MODE_X2  = 2'd1,
      MODE_X4  = 2'd2,
      MODE_X4B = 2'd3
   } mode_e;

   typedef struct packed {
      logic step;
      logic dir;
      logic err;
   } dec_t;

   // Levels are {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
   function automatic dec_t decode(input logic [1:0] prev,
                                   input logic [1:0] cur,
                                   input mode_e      mode);
      dec_t r;
      logic fwd;
      logic rev;
      logic a_chg;
      logic x1_edge;
      r       = '0;
      fwd     = (cur[1] == ~prev[0]) && (cur[0] == prev[1]);
      rev     = (prev[1] == ~cur[0]) && (prev[0] == cur[1]);
      a_chg   = prev[1] ^ cur[1];
      x1_edge = a_chg && !prev[0] && !cur[0];
      r.err   = (prev ^ cur) == 2'b11;
      case (mode)
         MODE_X1: r.step = (fwd | rev) & x1_edge;
         MODE_X2: r.step = (fwd | rev) & a_chg;
         default: r.step = fwd | rev;
      endcase
      r.dir = fwd;
      return r;
   endfunction

endpackage

// File: rtl/quad_dec_filt.sv
// Two-flop synchroniser plus stable-count glitch filter for one encoder line.
// q follows s2 after FILT_LEN mismatching cycles; while prime is high q loads s2 directly.
module quad_dec_filt #(
   parameter int FILT_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic prime,
   input  logic d,
   output logic s2,
   output logic q
);

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

   logic          s1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         q   <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
         if (prime) begin
            q   <= s2;
            cnt <= '0;
         end else if (s2 == q) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            q   <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/quad_dec.sv
// Multi-channel quadrature decoder: filtered A/B pairs drive per-channel position counters.
// Pin change to pos_o/step_o is FILT_LEN+2 edges; free-running, no backpressure.
module quad_dec
   import quad_dec_pkg::*;
#(
   parameter int CH       = 2,
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH-1:0]       a_i,
   input  logic [CH-1:0]       b_i,
   input  logic [1:0]          mode_i,
   input  logic [CH-1:0]       clr_i,
   input  logic [CH-1:0]       err_clr_i,
   output logic [CH*CNT_W-1:0] pos_o,
   output logic [CH-1:0]       dir_o,
   output logic [CH-1:0]       step_o,
   output logic [CH-1:0]       err_o
);

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic             a_s2;
      logic             b_s2;
      logic             a_f;
      logic             b_f;
      logic             prime;
      logic [1:0]       prime_cnt;
      logic [1:0]       prev;
      logic [CNT_W-1:0] pos;
      logic             dir_r;
      logic             step_r;
      logic             err_r;
      logic             step_hit;
      logic             err_hit;
      dec_t             dec;

      quad_dec_filt #(.FILT_LEN(FILT_LEN)) u_filt_a (
         .clk   (clk),
         .rst   (rst),
         .prime (prime),
         .d     (a_i[c]),
         .s2    (a_s2),
         .q     (a_f)
      );

      quad_dec_filt #(.FILT_LEN(FILT_LEN)) u_filt_b (
         .clk   (clk),
         .rst   (rst),
         .prime (prime),
         .d     (b_i[c]),
         .s2    (b_s2),
         .q     (b_f)
      );

      // The first three edges after reset only seed the filters and prev state.
      assign prime    = (prime_cnt != 2'd3);
      assign dec      = decode(prev, {a_f, b_f}, mode_e'(mode_i));
      assign step_hit = !prime && dec.step;
      assign err_hit  = !prime && dec.err;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            prime_cnt <= 2'd0;
            prev      <= 2'b00;
            pos       <= '0;
            dir_r     <= 1'b0;
            step_r    <= 1'b0;
            err_r     <= 1'b0;
         end else begin
            if (prime) begin
               prime_cnt <= prime_cnt + 2'd1;
               prev      <= {a_s2, b_s2};
            end else begin
               prev <= {a_f, b_f};
            end
            step_r <= step_hit;
            if (step_hit) begin
               dir_r <= dec.dir;
            end
            if (clr_i[c]) begin
               pos <= '0;
            end else if (step_hit) begin
               pos <= dec.dir ? pos + CNT_W'(1) : pos - CNT_W'(1);
            end
            if (err_clr_i[c]) begin
               err_r <= 1'b0;
            end else if (err_hit) begin
               err_r <= 1'b1;
            end
         end
      end

      assign pos_o[c*CNT_W +: CNT_W] = pos;
      assign dir_o[c]                = dir_r;
      assign step_o[c]               = step_r;
      assign err_o[c]                = err_r;
   end

endmodule

// File: tb/tb_quad_dec.sv
// Randomised scoreboard bench for quad_dec; reference model tracks each channel's
// position in the four-phase cycle and counts edges by mode with plain arithmetic.
module tb_quad_dec;
   localparam int CH    = 2;
   localparam int CNT_W = 6;
   localparam int FL    = 8;
   localparam int MODV  = 1 << CNT_W;
   localparam int HOLD  = FL + 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [CH-1:0]       a_i;
   logic [CH-1:0]       b_i;
   logic [1:0]          mode_i;
   logic [CH-1:0]       clr_i;
   logic [CH-1:0]       err_clr_i;
   logic [CH*CNT_W-1:0] pos_o;
   logic [CH-1:0]       dir_o;
   logic [CH-1:0]       step_o;
   logic [CH-1:0]       err_o;

   quad_dec #(.CH(CH), .CNT_W(CNT_W), .FILT_LEN(FL)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_i       (a_i),
      .b_i       (b_i),
      .mode_i    (mode_i),
      .clr_i     (clr_i),
      .err_clr_i (err_clr_i),
      .pos_o     (pos_o),
      .dir_o     (dir_o),
      .step_o    (step_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int pos;
      int dir;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   failures = 0;
   int   m_idx[CH];
   int   m_pos[CH];
   int   m_dir[CH];
   int   m_err[CH];
   int   e_cnt[CH];
   int   s_cnt[CH];
   int   m_mode;
   int   mk;

   function automatic logic [1:0] lvl(input int i);
      case (i)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   function automatic int pos_of(input int c);
      return int'(pos_o[c*CNT_W +: CNT_W]);
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input int m);
      m_mode = m;
      mode_i = 2'(m);
      cyc(2);
   endtask

   // Reference: x4 counts every quarter-cycle edge, x2 the A edges (0 and 2), x1 edge 0 only.
   task automatic model_move(input int c, input int ni, input bit clr_hit);
      int   d;
      int   ek;
      bit   fwd;
      bit   counts;
      exp_t e;
      d = (ni - m_idx[c] + 4) % 4;
      if (d == 0) return;
      m_idx[c] = ni;
      if (d == 2) begin
         m_err[c] = 1;
         return;
      end
      fwd = (d == 1);
      ek  = fwd ? (ni + 3) % 4 : ni;
      case (m_mode)
         0:       counts = (ek == 0);
         1:       counts = (ek % 2 == 0);
         default: counts = 1'b1;
      endcase
      if (!counts) return;
      m_pos[c] = clr_hit ? 0 : (m_pos[c] + (fwd ? 1 : MODV - 1)) % MODV;
      m_dir[c] = fwd ? 1 : 0;
      e_cnt[c]++;
      e.ch  = c;
      e.pos = m_pos[c];
      e.dir = m_dir[c];
      expq.push_back(e);
   endtask

   task automatic drive_idx(input int c, input int ni, input bit clr_hit);
      logic [1:0] l;
      l      = lvl(ni);
      a_i[c] = l[1];
      b_i[c] = l[0];
      model_move(c, ni, clr_hit);
   endtask

   task automatic step_ch(input int c, input bit fwd, input int hold);
      drive_idx(c, fwd ? (m_idx[c] + 1) % 4 : (m_idx[c] + 3) % 4, 1'b0);
      cyc(hold);
   endtask

   task automatic clear_pos(input int c);
      clr_i[c] = 1'b1;
      cyc(1);
      clr_i[c] = 1'b0;
      m_pos[c] = 0;
   endtask

   task automatic check_all(input string tag);
      for (int c = 0; c < CH; c++) begin
         chk($sformatf("%s_pos%0d", tag, c), pos_of(c), m_pos[c]);
         chk($sformatf("%s_steps%0d", tag, c), s_cnt[c], e_cnt[c]);
         chk($sformatf("%s_err%0d", tag, c), int'(err_o[c]), m_err[c]);
      end
   endtask

   // Monitor: every step pulse pops the oldest expectation for its channel.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         for (int c = 0; c < CH; c++) begin
            if (step_o[c] === 1'b1) begin
               s_cnt[c]++;
               mk = -1;
               for (int i = 0; i < expq.size(); i++) begin
                  if (mk < 0 && expq[i].ch == c) mk = i;
               end
               checks++;
               if (mk < 0) begin
                  failures++;
                  $display("FAIL step_unexpected ch%0d actual=pulse expected=none pos=%0d", c, pos_of(c));
               end else begin
                  if (pos_of(c) != expq[mk].pos || int'(dir_o[c]) != expq[mk].dir) begin
                     failures++;
                     $display("FAIL step_value ch%0d actual pos=%0d dir=%0d expected pos=%0d dir=%0d",
                              c, pos_of(c), dir_o[c], expq[mk].pos, expq[mk].dir);
                  end
                  expq.delete(mk);
               end
            end
         end
      end
   end

   initial begin
      rst       = 1'b0;
      a_i       = '1;
      b_i       = '1;
      clr_i     = '0;
      err_clr_i = '0;
      m_mode    = 2;
      mode_i    = 2'd2;
      for (int c = 0; c < CH; c++) begin
         m_idx[c] = 2;
         m_pos[c] = 0;
         m_dir[c] = 0;
         m_err[c] = 0;
         e_cnt[c] = 0;
         s_cnt[c] = 0;
      end

      // Reset with inputs resting at 11: outputs clear and no step after release.
      cyc(5);
      @(negedge clk);
      chk("rst_pos", int'(pos_o), 0);
      chk("rst_dir", int'(dir_o), 0);
      chk("rst_step", int'(step_o), 0);
      chk("rst_err", int'(err_o), 0);
      cyc(1);
      rst = 1'b1;
      cyc(50);
      check_all("prime");

      // x4: ten forward cycles then three reverse on channel 0.
      for (int i = 0; i < 40; i++) step_ch(0, 1'b1, 20);
      check_all("x4_fwd");
      chk("x4_fwd_dir", int'(dir_o[0]), m_dir[0]);
      for (int i = 0; i < 12; i++) step_ch(0, 1'b0, 20);
      check_all("x4_rev");
      chk("x4_rev_dir", int'(dir_o[0]), m_dir[0]);

      // x1 and x2: five cycles each way from a cleared count.
      for (int m = 0; m < 2; m++) begin
         clear_pos(0);
         set_mode(m);
         for (int i = 0; i < 20; i++) step_ch(0, 1'b1, HOLD);
         check_all($sformatf("m%0d_fwd", m));
         for (int i = 0; i < 20; i++) step_ch(0, 1'b0, HOLD);
         check_all($sformatf("m%0d_rev", m));
      end

      // Bounce on A from 00, then stable high: one step, exact latency.
      set_mode(2);
      while (m_idx[0] != 0) step_ch(0, 1'b1, HOLD);
      for (int i = 0; i < 30; i++) begin
         a_i[0] = 1'b1;
         cyc(3);
         a_i[0] = 1'b0;
         cyc(3);
      end
      drive_idx(0, 1, 1'b0);
      cyc(FL + 2);
      @(negedge clk);
      chk("bounce_early", int'(step_o[0]), 0);
      @(negedge clk);
      chk("bounce_step", int'(step_o[0]), 1);
      cyc(HOLD);
      check_all("bounce");

      // Wrap-around both ways, then clear coincident with a step.
      clear_pos(0);
      for (int i = 0; i < MODV - 1; i++) step_ch(0, 1'b1, HOLD);
      check_all("wrap_max");
      step_ch(0, 1'b1, HOLD);
      check_all("wrap_zero");
      step_ch(0, 1'b0, HOLD);
      check_all("wrap_under");
      step_ch(0, 1'b1, HOLD);
      drive_idx(0, (m_idx[0] + 1) % 4, 1'b1);
      cyc(FL + 2);
      clr_i[0] = 1'b1;
      @(posedge clk);
      #1;
      clr_i[0] = 1'b0;
      @(negedge clk);
      chk("clr_step", int'(step_o[0]), 1);
      chk("clr_pos", pos_of(0), 0);
      cyc(HOLD);
      check_all("clr");

      // Both lines of channel 0 flip together: sticky error, channel 1 untouched.
      drive_idx(0, (m_idx[0] + 2) % 4, 1'b0);
      cyc(HOLD + 2);
      check_all("err_set");
      cyc(20);
      chk("err_sticky", int'(err_o[0]), m_err[0]);
      err_clr_i[0] = 1'b1;
      cyc(1);
      err_clr_i[0] = 1'b0;
      m_err[0] = 0;
      @(negedge clk);
      chk("err_clr", int'(err_o[0]), 0);
      cyc(1);

      // Random walk on both channels, random mode per segment.
      for (int seg = 0; seg < 4; seg++) begin
         set_mode(int'($urandom_range(0, 3)));
         for (int ph = 0; ph < 40; ph++) begin
            for (int c = 0; c < CH; c++) begin
               int r;
               r = int'($urandom_range(0, 15));
               if (r < 6)       drive_idx(c, (m_idx[c] + 1) % 4, 1'b0);
               else if (r < 12) drive_idx(c, (m_idx[c] + 3) % 4, 1'b0);
               else if (r == 15) drive_idx(c, (m_idx[c] + 2) % 4, 1'b0);
            end
            cyc(int'($urandom_range(FL + 3, FL + 8)));
         end
         cyc(HOLD);
         check_all($sformatf("rnd%0d", seg));
         err_clr_i = '1;
         cyc(1);
         err_clr_i = '0;
         for (int c = 0; c < CH; c++) m_err[c] = 0;
         cyc(2);
      end

      // Reset mid-operation with inputs held: clears, then re-primes without a step.
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_pos", int'(pos_o), 0);
      chk("rstmid_dir", int'(dir_o), 0);
      chk("rstmid_err", int'(err_o), 0);
      for (int c = 0; c < CH; c++) begin
         m_pos[c] = 0;
         m_dir[c] = 0;
         m_err[c] = 0;
      end
      cyc(2);
      rst = 1'b1;
      cyc(40);
      check_all("rstmid");
      set_mode(2);
      for (int c = 0; c < CH; c++) drive_idx(c, (m_idx[c] + 1) % 4, 1'b0);
      cyc(HOLD);
      check_all("post_rst");

      chk("queue_empty", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
